key_calc_ctrl: RTL and testbench



---
 rtl/key_calc_pkg.sv | 58 +++++
 rtl/key_calc_ctrl_bin2bcd.sv | 68 ++++++
 rtl/key_calc_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_key_calc_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_calc_pkg.sv
// key_calc_pkg: shared constants and helpers for the keyboard calculator.
//   - PS/2 set-2 scancodes for digits, operators, Enter and Esc
//   - controller state and operator encodings
//   - RES_W: width of the binary result fed to the BCD converter
//   - decode_digit / bin7_to_bcd helpers
package key_calc_pkg;

  localparam int RES_W = 14;

  localparam logic [7:0] SC_D0    = 8'h45;
  localparam logic [7:0] SC_D1    = 8'h16;
  localparam logic [7:0] SC_D2    = 8'h1E;
  localparam logic [7:0] SC_D3    = 8'h26;
  localparam logic [7:0] SC_D4    = 8'h25;
  localparam logic [7:0] SC_D5    = 8'h2E;
  localparam logic [7:0] SC_D6    = 8'h36;
  localparam logic [7:0] SC_D7    = 8'h3D;
  localparam logic [7:0] SC_D8    = 8'h3E;
  localparam logic [7:0] SC_D9    = 8'h46;
  localparam logic [7:0] SC_ADD   = 8'h1C;
  localparam logic [7:0] SC_SUB   = 8'h1B;
  localparam logic [7:0] SC_MUL   = 8'h3A;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {S_OPA, S_OPB, S_CONV, S_RESULT} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  // Returns {is_digit, value}.
  function automatic logic [4:0] decode_digit(input logic [7:0] sc);
    case (sc)
      SC_D0:   return {1'b1, 4'd0};
      SC_D1:   return {1'b1, 4'd1};
      SC_D2:   return {1'b1, 4'd2};
      SC_D3:   return {1'b1, 4'd3};
      SC_D4:   return {1'b1, 4'd4};
      SC_D5:   return {1'b1, 4'd5};
      SC_D6:   return {1'b1, 4'd6};
      SC_D7:   return {1'b1, 4'd7};
      SC_D8:   return {1'b1, 4'd8};
      SC_D9:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // Combinational double-dabble for operands (0..99): returns {tens, ones}.
  function automatic logic [7:0] bin7_to_bcd(input logic [6:0] v);
    logic [14:0] sh;
    sh = {8'd0, v};
    for (int i = 0; i < 7; i++) begin
      if (sh[10:7] >= 4'd5) sh[10:7] = sh[10:7] + 4'd3;
      if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
      sh = sh << 1;
    end
    return sh[14:7];
  endfunction

endpackage

// File: rtl/key_calc_ctrl_bin2bcd.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to BCD converter.
//   clk, rst   : clock, asynchronous active-high reset
//   i_start    : one-cycle pulse, samples i_bin
//   i_bin      : RES_W-bit binary input
//   o_bcd      : 4 BCD digits (valid once o_done is seen)
//   o_last     : high in the cycle whose clock edge performs the final shift
//   o_done     : one-cycle pulse, CONV_CYCLES cycles after i_start
module bin2bcd_seq
  import key_calc_pkg::*;
#(
  parameter int CONV_CYCLES = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [RES_W-1:0] i_bin,
  output logic [15:0]      o_bcd,
  output logic             o_last,
  output logic             o_done
);

  localparam int SH_W  = 16 + RES_W;
  localparam int CNT_W = $clog2(CONV_CYCLES + 1);

  logic [SH_W-1:0]  r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_done;
  logic [SH_W-1:0]  w_adj;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  assign w_adj[RES_W-1:0] = r_sh[RES_W-1:0];
  for (genvar gi = 0; gi < 4; gi++) begin : g_add3
    assign w_adj[RES_W+4*gi +: 4] = (r_sh[RES_W+4*gi +: 4] >= 4'd5) ?
                                    r_sh[RES_W+4*gi +: 4] + 4'd3 :
                                    r_sh[RES_W+4*gi +: 4];
  end

  // The load edge also performs the first shift (BCD field is empty then),
  // so the final shift happens CONV_CYCLES-1 edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_sh     <= {16'd0, i_bin} << 1;
        r_cnt    <= CNT_W'(CONV_CYCLES - 1);
        r_active <= 1'b1;
      end else if (r_active) begin
        r_sh  <= w_adj << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_bcd  = r_sh[SH_W-1 -: 16];
  assign o_last = r_active && (r_cnt == CNT_W'(1));
  assign o_done = r_done;

endmodule

// File: rtl/key_calc_ctrl.sv
// key_calc_ctrl: two-operand decimal calculator driven by PS/2 key presses,
// with a time-multiplexed 4-digit 7-segment display.
//   clk, rst     : clock, asynchronous active-high reset
//   key_down     : per-scancode pressed map
//   last_change  : latest scancode, bit 8 = extended prefix
//   key_valid    : pulse on each make/break
//   ssd_ctl      : active-low one-hot digit enable, 4'b1111 = blank
//   ssd_bcd      : BCD value of the enabled digit
//   neg          : negative subtraction result (S_RESULT only)
//   busy         : BCD conversion in progress
module key_calc_ctrl
  import key_calc_pkg::*;
#(
  parameter int SCAN_BITS   = 17,
  parameter int CONV_CYCLES = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  output logic [3:0]   ssd_ctl,
  output logic [3:0]   ssd_bcd,
  output logic         neg,
  output logic         busy
);

  state_t             r_state;
  op_t                r_op;
  logic [6:0]         r_a, r_b;
  logic [1:0]         r_cnt_a, r_cnt_b;
  logic [RES_W-1:0]   r_res;
  logic               r_res_neg, r_start, r_busy, r_neg;
  logic [SCAN_BITS-1:0] r_scan;
  logic [3:0]         r_ssd_ctl, r_ssd_bcd;

  // Key event decode: only non-extended make codes count.
  logic       w_press;
  logic [7:0] w_sc;
  logic [4:0] w_dig;
  logic       w_is_digit, w_is_op, w_is_enter, w_is_esc;
  op_t        w_op;

  assign w_press    = key_valid && key_down[last_change] && !last_change[8];
  assign w_sc       = last_change[7:0];
  assign w_dig      = decode_digit(w_sc);
  assign w_is_digit = w_press && w_dig[4];
  assign w_is_op    = w_press && (w_sc == SC_ADD || w_sc == SC_SUB || w_sc == SC_MUL);
  assign w_is_enter = w_press && (w_sc == SC_ENTER);
  assign w_is_esc   = w_press && (w_sc == SC_ESC);

  always_comb begin
    w_op = OP_ADD;
    if (w_sc == SC_SUB) w_op = OP_SUB;
    else if (w_sc == SC_MUL) w_op = OP_MUL;
  end

  // Only evaluated while fewer than two digits are held, so the operand is
  // at most 9 and the 7-bit result cannot wrap.
  logic [6:0] w_a_next, w_b_next;
  assign w_a_next = 7'(r_a * 7'd10 + 7'(w_dig[3:0]));
  assign w_b_next = 7'(r_b * 7'd10 + 7'(w_dig[3:0]));

  logic [RES_W-1:0] w_res;
  logic             w_res_neg;
  always_comb begin
    w_res     = RES_W'(r_a) + RES_W'(r_b);
    w_res_neg = 1'b0;
    case (r_op)
      OP_SUB: begin
        w_res_neg = (r_a < r_b);
        w_res     = w_res_neg ? RES_W'(r_b - r_a) : RES_W'(r_a - r_b);
      end
      OP_MUL:  w_res = RES_W'(r_a) * RES_W'(r_b);
      default: w_res = RES_W'(r_a) + RES_W'(r_b);
    endcase
  end

  logic [15:0] w_bcd;
  logic        w_last;
  logic        w_done_unused;

  bin2bcd_seq #(.CONV_CYCLES(CONV_CYCLES)) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (r_start),
    .i_bin   (r_res),
    .o_bcd   (w_bcd),
    .o_last  (w_last),
    .o_done  (w_done_unused)
  );

  // Leaving S_CONV on the final-shift flag (rather than the done pulse)
  // makes S_RESULT coincide with the first cycle of valid BCD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_OPA;
      r_op      <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt_a   <= '0;
      r_cnt_b   <= '0;
      r_res     <= '0;
      r_res_neg <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_is_esc && r_state != S_CONV) begin
        r_state   <= S_OPA;
        r_op      <= OP_ADD;
        r_a       <= '0;
        r_b       <= '0;
        r_cnt_a   <= '0;
        r_cnt_b   <= '0;
        r_res     <= '0;
        r_res_neg <= 1'b0;
        r_busy    <= 1'b0;
        r_neg     <= 1'b0;
      end else begin
        case (r_state)
          S_OPA: begin
            if (w_is_digit && r_cnt_a < 2'd2) begin
              r_a     <= w_a_next;
              r_cnt_a <= r_cnt_a + 2'd1;
            end else if (w_is_op && r_cnt_a != 2'd0) begin
              r_op    <= w_op;
              r_state <= S_OPB;
            end
          end
          S_OPB: begin
            if (w_is_digit && r_cnt_b < 2'd2) begin
              r_b     <= w_b_next;
              r_cnt_b <= r_cnt_b + 2'd1;
            end else if (w_is_op) begin
              r_op <= w_op;
            end else if (w_is_enter && r_cnt_b != 2'd0) begin
              r_res     <= w_res;
              r_res_neg <= w_res_neg;
              r_start   <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= S_CONV;
            end
          end
          S_CONV: begin
            if (w_last) begin
              r_busy  <= 1'b0;
              r_neg   <= r_res_neg;
              r_state <= S_RESULT;
            end
          end
          default: begin
            if (w_is_digit) begin
              r_a     <= 7'(w_dig[3:0]);
              r_cnt_a <= 2'd1;
              r_b     <= '0;
              r_cnt_b <= '0;
              r_neg   <= 1'b0;
              r_state <= S_OPA;
            end else if (w_is_op && !r_res_neg && r_res <= RES_W'(99)) begin
              // Chain: the previous result becomes operand A.
              r_a     <= 7'(r_res);
              r_cnt_a <= 2'd2;
              r_b     <= '0;
              r_cnt_b <= '0;
              r_op    <= w_op;
              r_neg   <= 1'b0;
              r_state <= S_OPB;
            end
          end
        endcase
      end
    end
  end

  // Display content and leading-zero blanking.
  logic [7:0]  w_a_bcd, w_b_bcd;
  logic [15:0] w_digits;
  logic [3:0]  w_show, w_res_show;
  logic [1:0]  w_idx;

  assign w_a_bcd = bin7_to_bcd(r_a);
  assign w_b_bcd = bin7_to_bcd(r_b);

  // A result digit is lit when it or any more-significant digit is nonzero.
  assign w_res_show[0] = 1'b1;
  for (genvar gi = 1; gi < 4; gi++) begin : g_res_blank
    assign w_res_show[gi] = |w_bcd[15:4*gi];
  end

  always_comb begin
    w_digits = 16'h0000;
    w_show   = 4'b0001;
    case (r_state)
      S_OPA: begin
        w_digits = {8'h00, w_a_bcd};
        w_show   = {2'b00, (w_a_bcd[7:4] != 4'd0), 1'b1};
      end
      S_OPB, S_CONV: begin
        w_digits = {8'h00, w_b_bcd};
        w_show   = {2'b00, (w_b_bcd[7:4] != 4'd0), 1'b1};
      end
      default: begin
        w_digits = w_bcd;
        w_show   = w_res_show;
      end
    endcase
  end

  assign w_idx = r_scan[SCAN_BITS-1 -: 2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan    <= '0;
      r_ssd_ctl <= 4'b1110;
      r_ssd_bcd <= 4'd0;
    end else begin
      r_scan    <= r_scan + 1'b1;
      r_ssd_ctl <= w_show[w_idx] ? ~(4'b0001 << w_idx) : 4'b1111;
      r_ssd_bcd <= w_show[w_idx] ? w_digits[{w_idx, 2'b00} +: 4] : 4'd0;
    end
  end

  assign ssd_ctl = r_ssd_ctl;
  assign ssd_bcd = r_ssd_bcd;
  assign neg     = r_neg;
  assign busy    = r_busy;

endmodule

// File: tb/tb_key_calc_ctrl.sv
module tb_key_calc_ctrl;

  localparam int SCAN_BITS = 4;   // 4 cycles per digit, 16-cycle frame

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         key_valid = 1'b0;
  logic [3:0]   ssd_ctl, ssd_bcd;
  logic         neg, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_calc_ctrl #(.SCAN_BITS(SCAN_BITS), .CONV_CYCLES(14)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .ssd_ctl     (ssd_ctl),
    .ssd_bcd     (ssd_bcd),
    .neg         (neg),
    .busy        (busy)
  );

  typedef struct {
    string       name;
    logic [15:0] dig;
    logic [3:0]  show;
    bit          neg;
  } exp_t;

  typedef struct {
    string keys;
    exp_t  exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[11];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [8:0] sc_of(byte c);
    case (c)
      "0": return 9'h045;
      "1": return 9'h016;
      "2": return 9'h01E;
      "3": return 9'h026;
      "4": return 9'h025;
      "5": return 9'h02E;
      "6": return 9'h036;
      "7": return 9'h03D;
      "8": return 9'h03E;
      "9": return 9'h046;
      "+": return 9'h01C;
      "-": return 9'h01B;
      "*": return 9'h03A;
      "=": return 9'h05A;
      "E": return 9'h076;
      "X": return 9'h15A;
      default: return 9'h000;
    endcase
  endfunction

  function automatic vec_t mk(string k, logic [15:0] d, logic [3:0] s, bit ng);
    vec_t v;
    v.keys     = k;
    v.exp.name = k;
    v.exp.dig  = d;
    v.exp.show = s;
    v.exp.neg  = ng;
    return v;
  endfunction

  // One make or break event; key_valid is high for exactly one cycle.
  task automatic pulse(logic [8:0] sc, bit down);
    @(posedge clk); #1;
    last_change  = sc;
    key_down[sc] = down;
    key_valid    = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic press(byte c);
    pulse(sc_of(c), 1'b1);
    pulse(sc_of(c), 1'b0);
  endtask

  task automatic press_str(string s);
    for (int i = 0; i < s.len(); i++) press(s[i]);
  endtask

  // Observe one full scan frame; every lit digit must be lit 4 cycles with
  // the expected value, every blank digit never lit.
  task automatic check_display(string name, logic [15:0] dig, logic [3:0] show);
    int lit[4];
    int bad[4];
    int junk = 0;
    int d;
    for (int i = 0; i < 4; i++) begin lit[i] = 0; bad[i] = 0; end
    repeat (16) begin
      @(negedge clk);
      case (ssd_ctl)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        4'b1111: d = -1;
        default: begin d = -2; junk++; end
      endcase
      if (d >= 0) begin
        lit[d]++;
        if (ssd_bcd !== dig[d*4 +: 4]) bad[d]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s digit%0d lit cycles", name, i), lit[i], show[i] ? 4 : 0);
      if (show[i]) check($sformatf("%s digit%0d wrong-value cycles", name, i), bad[i], 0);
    end
    check({name, " invalid ssd_ctl cycles"}, junk, 0);
  endtask

  // Enter event in cycle E: busy expected from E+1 for exactly 14 cycles.
  task automatic enter_and_check(exp_t e);
    int first = 0;
    int cnt   = 0;
    exp_t x;
    sb_q.push_back(e);
    pulse(sc_of("="), 1'b1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) begin
        if (first == 0) first = i;
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
    end
    check({e.name, " busy first cycle after Enter"}, first, 1);
    check({e.name, " busy length"}, cnt, 14);
    pulse(sc_of("="), 1'b0);
    if (sb_q.size() == 0) begin
      check({e.name, " scoreboard empty"}, 1, 0);
    end else begin
      x = sb_q.pop_front();
      check_display(x.name, x.dig, x.show);
      check({x.name, " neg"}, neg, x.neg);
      $display("[TB] %s -> expected %0h", x.name, x.dig);
    end
  endtask

  // Final '=' is the measured Enter; earlier ones are plain presses.
  task automatic run_vec(vec_t v);
    for (int i = 0; i < v.keys.len(); i++) begin
      if (v.keys[i] == "=" && i == v.keys.len() - 1) enter_and_check(v.exp);
      else press(v.keys[i]);
    end
  endtask

  function automatic exp_t ex(string n, logic [15:0] d, logic [3:0] s, bit ng);
    exp_t e;
    e.name = n; e.dig = d; e.show = s; e.neg = ng;
    return e;
  endfunction

  initial begin
    int bcnt;

    vecs[0]  = mk("E123-50=", 16'h0038, 4'b0011, 1'b1);
    vecs[1]  = mk("E99*99=",  16'h9801, 4'b1111, 1'b0);
    vecs[2]  = mk("E0-0=",    16'h0000, 4'b0001, 1'b0);
    vecs[3]  = mk("E5+-3=",   16'h0002, 4'b0001, 1'b0);
    vecs[4]  = mk("E99+99=",  16'h0198, 4'b0111, 1'b0);
    vecs[5]  = mk("E2*=3=",   16'h0006, 4'b0001, 1'b0);
    vecs[6]  = mk("E+8*10=",  16'h0080, 4'b0011, 1'b0);
    vecs[7]  = mk("E=7=-2=",  16'h0005, 4'b0001, 1'b0);
    vecs[8]  = mk("E10-10=",  16'h0000, 4'b0001, 1'b0);
    vecs[9]  = mk("E9-99=",   16'h0090, 4'b0011, 1'b1);
    vecs[10] = mk("E50*2=",   16'h0100, 4'b0111, 1'b0);

    // Reset values and the idle scan pattern.
    repeat (3) @(posedge clk);
    #1;
    check("reset ssd_ctl", ssd_ctl, 4'b1110);
    check("reset ssd_bcd", ssd_bcd, 4'd0);
    check("reset busy", busy, 1'b0);
    check("reset neg", neg, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("idle scan cycle %0d ssd_ctl", k), ssd_ctl, (k <= 4) ? 4'b1110 : 4'b1111);
      if (k == 1) check("idle digit0 ssd_bcd", ssd_bcd, 4'd0);
    end
    $display("[TB] reset/idle scan checked");

    // 4 2 + 7 Enter, then chain + 1 Enter, then Esc.
    press_str("42");
    check_display("A=42", 16'h0042, 4'b0011);
    press_str("+7");
    check_display("B=7", 16'h0007, 4'b0001);
    enter_and_check(ex("42+7", 16'h0049, 4'b0011, 1'b0));
    press_str("+1");
    enter_and_check(ex("49+1 chained", 16'h0050, 4'b0011, 1'b0));
    press("E");
    check("esc from result busy", busy, 1'b0);
    check("esc from result neg", neg, 1'b0);
    check_display("after esc", 16'h0000, 4'b0001);
    press("5");
    check_display("new A=5", 16'h0005, 4'b0001);

    // Table of complete calculations.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Keys during S_CONV are dropped, including Esc.
    press_str("E3+4");
    pulse(sc_of("="), 1'b1);
    press("9");
    press("E");
    press("*");
    for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    check("conv keys: busy ended", busy, 1'b0);
    pulse(sc_of("="), 1'b0);
    check_display("conv keys ignored 3+4", 16'h0007, 4'b0001);
    $display("[TB] keys during conversion checked");

    // Chain 7*, then an extended-prefix Enter in S_OPB must be ignored.
    press_str("*2");
    press("X");
    bcnt = 0;
    repeat (4) begin @(negedge clk); if (busy) bcnt++; end
    check("extended enter busy cycles", bcnt, 0);
    check_display("extended enter B=2", 16'h0002, 4'b0001);
    enter_and_check(ex("7*2 chained", 16'h0014, 4'b0011, 1'b0));

    // Asynchronous reset in the middle of S_OPB.
    press_str("E5+");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst in OPB ssd_ctl", ssd_ctl, 4'b1110);
    check("rst in OPB ssd_bcd", ssd_bcd, 4'd0);
    check("rst in OPB busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    press("3");
    check_display("after rst A=3", 16'h0003, 4'b0001);
    press_str("+4");
    enter_and_check(ex("3+4 after rst", 16'h0007, 4'b0011 & 4'b0001, 1'b0));

    // Asynchronous reset in the middle of a conversion.
    press_str("E9*9");
    pulse(sc_of("="), 1'b1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst in CONV busy", busy, 1'b0);
    key_down[9'h05A] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bcnt = 0;
    repeat (20) begin @(negedge clk); if (busy || neg) bcnt++; end
    check("after rst in CONV busy/neg cycles", bcnt, 0);
    check_display("after rst in CONV", 16'h0000, 4'b0001);
    press("6");
    check_display("after rst in CONV A=6", 16'h0006, 4'b0001);

    // Esc from a negative result.
    press("E");
    press_str("1-9");
    enter_and_check(ex("1-9", 16'h0008, 4'b0001, 1'b1));
    press("E");
    check("esc clears neg", neg, 1'b0);
    check_display("esc after neg", 16'h0000, 4'b0001);
    press_str("6*3");
    enter_and_check(ex("6*3 after esc", 16'h0018, 4'b0011, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
